// File: rtl/rect_point_gen.sv
// Rectangle point generator: walks a latched rectangle row by row and emits
// one (x, y) point per accepted transfer, either filled or outline only.
module rect_point_gen #(
   parameter int WIDTH   = 32,
   parameter bit FILL_EN = 1'b1
) (
   input  logic                    _clock,
   input  logic                    _reset_n,
   input  logic                    _start,
   input  logic                    _mode,
   input  logic signed [WIDTH-1:0] s_x,
   input  logic signed [WIDTH-1:0] s_y,
   input  logic signed [WIDTH-1:0] width,
   input  logic signed [WIDTH-1:0] height,
   input  logic                    _ready,
   output logic                    _valid,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1,
   output logic        [WIDTH-1:0] _count,
   output logic                    _done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d, w_q, w_d, h_q, h_d;
   logic        [WIDTH-1:0] c_q, c_d, r_q, r_d, count_q, count_d;
   logic                    fill_q, fill_d, done_q, done_d;
   logic        [WIDTH-1:0] w_last, h_last;
   logic                    empty_rect;

   assign w_last     = w_q - 1'b1;
   assign h_last     = h_q - 1'b1;
   assign empty_rect = width[WIDTH-1] || (width == '0) || height[WIDTH-1] || (height == '0);

   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state_q <= IDLE;
         sx_q    <= '0;
         sy_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         c_q     <= '0;
         r_q     <= '0;
         count_q <= '0;
         fill_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         w_q     <= w_d;
         h_q     <= h_d;
         c_q     <= c_d;
         r_q     <= r_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      w_d     = w_q;
      h_d     = h_q;
      c_d     = c_q;
      r_d     = r_q;
      count_d = count_q;
      fill_d  = fill_q;
      done_d  = done_q;
      case (state_q)
         IDLE, DONE: begin
            if (_start) begin
               sx_d    = s_x;
               sy_d    = s_y;
               w_d     = width;
               h_d     = height;
               fill_d  = _mode && FILL_EN;
               c_d     = '0;
               r_d     = '0;
               count_d = '0;
               done_d  = empty_rect;
               state_d = empty_rect ? DONE : RUN;
            end
         end
         RUN: begin
            if (_ready) begin
               count_d = count_q + 1'b1;
               if (c_q == w_last) begin
                  if (r_q == h_last) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     c_d = '0;
                     r_d = r_q + 1'b1;
                  end
               // Interior outline rows only have their two edge columns.
               end else if (!fill_q && (r_q != '0) && (r_q != h_last)) begin
                  c_d = w_last;
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign _valid = (state_q == RUN);
   assign _out0  = sx_q + $signed(c_q);
   assign _out1  = sy_q + $signed(r_q);
   assign _count = count_q;
   assign _done  = done_q;

endmodule

// File: tb/tb_rect_point_gen.sv
// Randomized bench for rect_point_gen (WIDTH=8) against a loop-based point-list model.
module tb_rect_point_gen;

   logic              clk, rst_n, start, mode, ready;
   logic signed [7:0] sx, sy, w, h, out0, out1;
   logic        [7:0] count;
   logic              valid, done;
   int                n_checks = 0;
   int                n_pass   = 0;
   int                rdy_pat[$];

   rect_point_gen #(.WIDTH(8), .FILL_EN(1'b1)) dut (
      ._clock(clk), ._reset_n(rst_n), ._start(start), ._mode(mode),
      .s_x(sx), .s_y(sy), .width(w), .height(h), ._ready(ready),
      ._valid(valid), ._out0(out0), ._out1(out1), ._count(count), ._done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic pick_ready(input int rmode);
      if (rmode == 2 && rdy_pat.size() > 0) return logic'(rdy_pat.pop_front());
      if (rmode == 1) return logic'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   // Call just after a falling edge; returns just after a falling edge.
   task automatic run_rect(input bit m, input int px, input int py, input int pw, input int ph,
                           input int rmode, input bit poke);
      logic [15:0] exp_q[$];
      int idx = 0;
      int poked = 0;
      bit fin = 0;
      for (int r = 0; r < ph; r++)
         for (int c = 0; c < pw; c++)
            if (m || r == 0 || r == ph - 1 || c == 0 || c == pw - 1)
               exp_q.push_back({8'(px + c), 8'(py + r)});
      start = 1'b1; mode = m;
      sx = 8'(px); sy = 8'(py); w = 8'(pw); h = 8'(ph);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         if (poked == 1) begin start = 1'b0; poked = 2; end
         if (valid) begin
            chk("done_low", done, 0);
            if (idx < exp_q.size()) chk("point", {out0, out1}, exp_q[idx]);
            else chk("extra_point", idx, exp_q.size());
            if (poke && poked == 0) begin
               start = 1'b1; mode = ~m;
               sx = 8'($urandom); sy = 8'($urandom); w = 8'd3; h = 8'd2;
               poked = 1;
            end
            ready = pick_ready(rmode);
            if (ready) idx++;
         end else if (done) begin
            fin = 1;
         end else begin
            ready = pick_ready(rmode);
         end
      end
      start = 1'b0;
      chk("finish", fin, 1);
      chk("done", done, 1);
      chk("valid_off", valid, 0);
      chk("npoints", idx, exp_q.size());
      chk("count", count, exp_q.size());
      $display("rect mode=%0d org=(%0d,%0d) size=%0dx%0d points=%0d count=%0d",
               m, px, py, pw, ph, idx, count);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0;
      sx = '0; sy = '0; w = '0; h = '0;
      #12;
      chk("rst_valid", valid, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_out", {out0, out1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_rect(1'b1, 23, 17, 0, 5, 0, 1'b0);
      run_rect(1'b0, 0, 0, 3, 3, 0, 1'b0);
      run_rect(1'b1, 5, -2, 2, 2, 0, 1'b0);
      rdy_pat = '{1, 0, 0, 1, 1};
      run_rect(1'b1, 10, 20, 3, 1, 2, 1'b0);
      run_rect(1'b1, 127, 0, 2, 1, 0, 1'b0);
      run_rect(1'b0, -3, 4, 1, 4, 1, 1'b0);
      run_rect(1'b0, 7, 7, 4, 1, 1, 1'b0);

      // Reset in the middle of a 4x4 outline.
      start = 1'b1; mode = 1'b0; sx = '0; sy = '0; w = 8'd4; h = 8'd4; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("count_pre_rst", count, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_out", {out0, out1}, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_idle", valid, 0);
      end
      run_rect(1'b1, 9, 9, 1, 1, 0, 1'b0);

      for (int t = 0; t < 40; t++)
         run_rect(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 7)) - 1,
                  int'($urandom_range(0, 7)) - 1, 1, 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rect_point_gen.md
RECT_POINT_GEN -- requirements
Module: rect_point_gen

Interface
REQ-001 Parameter WIDTH, default 32: bit width of all signed coordinate and size ports.
REQ-002 Parameter FILL_EN, default 1: 1 enables filled mode; 0 forces outline mode regardless of _mode.
REQ-003 Port _clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port _reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port _start  input  1  request a new rectangle; sampled on rising edge.
REQ-006 Port _mode  input  1  0 = outline, 1 = filled; latched with _start.
REQ-007 Port s_x, s_y  input  WIDTH each, signed  origin (x = column, y = row); latched with _start.
REQ-008 Port width, height  input  WIDTH each, signed  size in columns/rows; latched with _start.
REQ-009 Port _ready  input  1  downstream accepts the current point.
REQ-010 Port _valid  output  1  _out0/_out1 hold a point.
REQ-011 Port _out0, _out1  output  WIDTH each, signed  x and y of the current point.
REQ-012 Port _count  output  WIDTH, unsigned  number of points accepted since the last start.
REQ-013 Port _done  output  1  rectangle complete; level signal.

Function
REQ-014 States IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE or DONE with _start=1: latch inputs, clear _count, clear _done, enter RUN; the first point is valid on the next cycle.
REQ-016 _start while in RUN shall be ignored; latched inputs unchanged.
REQ-017 width<=0 or height<=0 at start: enter DONE directly with no point emitted; _done=1 on the cycle after _start.
REQ-018 Order: row r from 0 to height-1, within each row column c from 0 to width-1; point = (s_x+c, s_y+r).
REQ-019 Filled mode: every (c,r) is emitted.
REQ-020 Outline mode: only points with r=0, r=height-1, c=0 or c=width-1; on interior rows, c jumps from 0 to width-1 in one step; no point is emitted twice.
REQ-021 width=1 or height=1 in outline mode: every point is emitted exactly once (degenerate line).
REQ-022 A point transfers on a cycle with _valid=1 and _ready=1; the next point (or _valid=0 after the last) appears the following cycle; sustained throughput is 1 point/cycle.
REQ-023 _valid=1 and _ready=0: _out0, _out1 and _valid shall hold stable.
REQ-024 _count increments by 1 on each transfer; the final value equals the total point count (filled: W*H; outline: W*H when W<=2 or H<=2, else 2W+2H-4).
REQ-025 Transfer of the last point: next cycle _valid=0, _done=1, state DONE; _done stays 1 until the next accepted _start.
REQ-026 Coordinate adds wrap modulo 2^WIDTH (two's complement); no saturation and no error flag.
REQ-027 Internal row/column counters shall be WIDTH bits; no points are lost for sizes up to 2^(WIDTH-1)-1.
REQ-028 _valid shall be 0 in IDLE and DONE.

Reset
REQ-029 _reset_n=0 forces, without a clock: state IDLE, _valid=0, _done=0, _count=0, _out0=0, _out1=0.
REQ-030 Reset during RUN abandons the rectangle; after release, no point is emitted until a new _start.
REQ-031 The first _start is honoured on the first rising edge after _reset_n rises.

Verification
REQ-032 s_x=23, s_y=17, height=5, width=0, _start pulse -> no _valid; _done=1 one cycle later; _count=0.
REQ-033 Outline, (0,0), width=3, height=3, _ready=1 -> 8 consecutive points (0,0)(1,0)(2,0)(0,1)(2,1)(0,2)(1,2)(2,2); then _done=1; _count=8.
REQ-034 Filled, (5,-2), width=2, height=2 -> points (5,-2)(6,-2)(5,-1)(6,-1); _count=4.
REQ-035 Filled 3x1 with _ready toggling 1,0,0,1,1 -> each point held while _ready=0; order and _count=3 preserved.
REQ-036 WIDTH=8, s_x=127, width=2, height=1 -> x values 127 then -128.
REQ-037 Reset pulse after the 2nd point of a 4x4 outline -> outputs zero at once; after release, a new 1x1 start at (9,9) yields a single point (9,9) and _done.
